// File: rtl/bin_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bin_bcd_seq_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Smallest digit count whose decimal range covers every BIN_W-bit value.
  function automatic int unsigned min_digits(input int unsigned bin_w);
    logic [63:0]  lim;
    logic [63:0]  p;
    int unsigned  d;
    lim = 64'd1 << bin_w;
    p   = 64'd1;
    d   = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (p < lim) begin
        p = p * 64'd10;
        d++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin_bcd_seq_if.sv
// start/busy/done handshake and data bus of the binary-to-BCD converter.
interface bin_bcd_seq_if
  import bin_bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
);

  logic                          start;
  logic [BIN_W-1:0]              bin_in;
  logic                          busy;
  logic                          done;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;

  modport master (output start, bin_in, input busy, done, bcd_out);
  modport slave  (input start, bin_in, output busy, done, bcd_out);

endinterface

// File: rtl/bin_bcd_seq_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_add3_digit
  import bin_bcd_seq_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
module bin_bcd_seq
  import bin_bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
)(
  input  logic           clk,
  input  logic           rst,
  bin_bcd_seq_if.slave   bus
);

  localparam int unsigned SW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CW = $clog2(BIN_W + 1);

  if (DIGITS < min_digits(BIN_W)) begin : g_digits_chk
    $error("bin_bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  state_t           state, state_nxt;
  logic [BIN_W-1:0] shreg, shreg_nxt;
  logic [SW-1:0]    scratch, scratch_nxt;
  logic [SW-1:0]    adj;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [SW-1:0]    bcd_q, bcd_nxt;
  logic             done_q, done_nxt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .din  (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      scratch <= scratch_nxt;
      cnt     <= cnt_nxt;
      bcd_q   <= bcd_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    scratch_nxt = scratch;
    cnt_nxt     = cnt;
    bcd_nxt     = bcd_q;
    done_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt   = ST_SHIFT;
          shreg_nxt   = bus.bin_in;
          scratch_nxt = '0;
          cnt_nxt     = CW'(BIN_W);
        end
      end
      ST_SHIFT: begin
        // Corrected digits and the remaining binary bits shift as one register.
        {scratch_nxt, shreg_nxt} = {adj, shreg} << 1;
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          bcd_nxt   = scratch_nxt;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.busy    = (state == ST_SHIFT);
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Scoreboard bench for bin_bcd_seq (8-bit/3-digit and 4-bit/2-digit builds).
module tb_bin_bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) bus8 ();
  bin_bcd_seq_if #(.BIN_W(4), .DIGITS(2)) bus4 ();

  bin_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  bin_bcd_seq #(.BIN_W(4), .DIGITS(2)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_done = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_e;
  bit          mon_en    = 1'b0;
  logic        prev_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [11:0] bcd12(input int unsigned v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic digits_ok(input logic [11:0] b);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
  endfunction

  // Scoreboard consumer: every done pulse pops and checks one expected result.
  always @(negedge clk) begin
    if (mon_en && bus8.done) begin
      n_done++;
      chk("done_1cyc", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("sb_empty_on_done", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("bcd_out", {20'd0, bus8.bcd_out}, {20'd0, mon_e});
        chk("digit_range", {31'd0, digits_ok(bus8.bcd_out)}, 32'd1);
      end
    end
    prev_done = bus8.done;
  end

  task automatic issue(input int unsigned v);
    bus8.start  = 1'b1;
    bus8.bin_in = 8'(v);
    exp_q.push_back(bcd12(v));
  endtask

  task automatic wait_done(input bit chk_busy, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) bus8.start = 1'b0;
      n = i;
      if (bus8.done) break;
      if (chk_busy) chk("busy_during", {31'd0, bus8.busy}, 32'd1);
    end
    chk("done_seen", {31'd0, bus8.done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int unsigned nd0;
    logic [4:0] d5;
    int unsigned dec;

    bus8.start = 1'b0; bus8.bin_in = '0;
    bus4.start = 1'b0; bus4.bin_in = '0;

    #12;
    chk("rst_busy", {31'd0, bus8.busy}, 32'd0);
    chk("rst_done", {31'd0, bus8.done}, 32'd0);
    chk("rst_bcd",  {20'd0, bus8.bcd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // 255: busy for 8 cycles, done on the 8th edge after acceptance.
    @(negedge clk);
    issue(255);
    wait_done(1'b1, n);
    chk("lat_255", n, 9);
    chk("busy_low_at_done", {31'd0, bus8.busy}, 32'd0);

    // Back-to-back with start asserted during each done cycle.
    @(negedge clk);
    issue(0);
    wait_done(1'b0, n);
    issue(99);
    wait_done(1'b0, n);
    chk("b2b_99_spacing", n, 9);
    issue(15);
    wait_done(1'b0, n);
    chk("b2b_15_spacing", n, 9);
    d5  = bus8.bcd_out[4:0];
    dec = 32'(d5[4]) * 10 + 32'(d5[3:0]);
    chk("decoder_15", dec, 32'b1111);

    // Start during a conversion is ignored.
    @(negedge clk);
    issue(200);
    nd0 = n_done;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) bus8.start = 1'b0;
    end
    bus8.start  = 1'b1;
    bus8.bin_in = 8'd7;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (12) @(negedge clk);
    chk("one_done_only", n_done - nd0, 1);
    chk("hold_200", {20'd0, bus8.bcd_out}, 32'h200);

    // Asynchronous reset mid-conversion.
    @(negedge clk);
    issue(128);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) bus8.start = 1'b0;
    end
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, bus8.busy}, 32'd0);
    chk("arst_done", {31'd0, bus8.done}, 32'd0);
    chk("arst_bcd",  {20'd0, bus8.bcd_out}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    nd0 = n_done;
    repeat (12) @(negedge clk);
    chk("no_done_after_rst", n_done - nd0, 0);
    issue(64);
    wait_done(1'b0, n);
    chk("val_64", {20'd0, bus8.bcd_out}, 32'h064);

    // Exhaustive sweep, chained through the done cycle.
    @(negedge clk);
    for (int unsigned v = 0; v < 256; v++) begin
      issue(v);
      wait_done(1'b0, n);
    end

    // Narrow build: 4-bit input, 2 digits.
    @(negedge clk);
    bus4.start  = 1'b1;
    bus4.bin_in = 4'd15;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) bus4.start = 1'b0;
      n = i;
      if (bus4.done) break;
    end
    chk("bcd4_latency", n, 5);
    chk("bcd4_val", {24'd0, bus4.bcd_out}, 32'h15);

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
